// File: rtl/tdm_pkg.sv
// tdm_pkg: shared definitions for the TDM multiplexer/demultiplexer family.
//   - tdm_state_e : framing state encoding (HUNT=0, RECV=1)
//   - slot_width(): clog2-based width of a slot counter for a given channel count
//   - TDM_SLOT_W  : slot counter width for the default 4-channel configuration
package tdm_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        RECV = 1'b1
    } tdm_state_e;

    localparam int TDM_N_CH_DEFAULT = 4;

    // Width of a counter that must reach n_ch-1; at least one bit.
    function automatic int slot_width(input int n_ch);
        return (n_ch > 2) ? $clog2(n_ch) : 1;
    endfunction

    localparam int TDM_SLOT_W = slot_width(TDM_N_CH_DEFAULT);

endpackage

// File: rtl/tdm_slot_counter.sv
// tdm_slot_counter: slot index counter for the TDM demultiplexer.
//   clk, rst : clock, asynchronous active-high reset
//   load1    : load the value 1 (slot 0 was just captured)
//   inc      : advance to the next slot
//   clr      : return to slot 0 (highest priority)
//   slot     : current slot index, never above N_CH-1
//   tc       : slot is at the last slot of the frame (N_CH-1)
module tdm_slot_counter
    import tdm_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int SW   = slot_width(N_CH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load1,
    input  logic          inc,
    input  logic          clr,
    output logic [SW-1:0] slot,
    output logic          tc
);

    logic [SW-1:0] slot_r;

    // Slot register: clear has priority over load, load over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_r <= '0;
        end else if (clr) begin
            slot_r <= '0;
        end else if (load1) begin
            slot_r <= SW'(1);
        end else if (inc) begin
            slot_r <= slot_r + SW'(1);
        end else begin
            slot_r <= slot_r;
        end
    end

    assign slot = slot_r;
    assign tc   = (slot_r == SW'(N_CH - 1));

endmodule

// File: rtl/tdm_demux.sv
// tdm_demux: time-division demultiplexer. Collects one W-bit sample per slot,
// framed by a slot-0 marker, and publishes all N_CH channels together once per
// complete frame.
//   clk, rst    : clock, asynchronous active-high reset
//   din         : sample for the current slot
//   din_valid   : din carries a sample this cycle
//   frame_sync  : din is slot 0 (only meaningful with din_valid)
//   dout        : channel i at dout[i*W +: W], updated only on frame completion
//   frame_valid : one-cycle strobe, dout just updated with a full frame
//   sync_err    : one-cycle strobe, frame aborted by an early frame_sync
// Build option: TDM_DEMUX_FLYWHEEL_EN keeps the receiver in RECV after each
// frame so only the first frame needs a marker.
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [W-1:0]      din,
    input  logic              din_valid,
    input  logic              frame_sync,
    output logic [N_CH*W-1:0] dout,
    output logic              frame_valid,
    output logic              sync_err
);

    localparam int SW = slot_width(N_CH);

    tdm_state_e         state_r;
    logic [W-1:0]       shadow_r [0:N_CH-2];
    logic [N_CH*W-1:0]  dout_r;
    logic               frame_valid_r;
    logic               sync_err_r;

    logic [SW-1:0]      slot_s;
    logic               tc_s;
    logic               load1_s;
    logic               inc_s;
    logic               clr_s;
    logic               start_s;     // din is captured as slot 0
    logic               abort_s;     // early frame_sync inside a frame
    logic               complete_s;  // din is the last slot of the frame
    logic [N_CH*W-1:0]  frame_word_s;

    tdm_slot_counter #(
        .N_CH (N_CH),
        .SW   (SW)
    ) u_slot_counter (
        .clk   (clk),
        .rst   (rst),
        .load1 (load1_s),
        .inc   (inc_s),
        .clr   (clr_s),
        .slot  (slot_s),
        .tc    (tc_s)
    );

    // Decode what the current sample does to the frame in progress.
    always_comb begin
        start_s    = 1'b0;
        abort_s    = 1'b0;
        complete_s = 1'b0;
        inc_s      = 1'b0;
        if (din_valid) begin
            case (state_r)
                HUNT: begin
                    start_s = frame_sync;
                end
                RECV: begin
                    if (slot_s == '0) begin
                        // Only reachable in flywheel mode: slot 0 needs no marker.
                        start_s = 1'b1;
                    end else if (frame_sync) begin
                        start_s = 1'b1;
                        abort_s = 1'b1;
                    end else if (tc_s) begin
                        complete_s = 1'b1;
                    end else begin
                        inc_s = 1'b1;
                    end
                end
                default: begin
                    start_s = 1'b0;
                end
            endcase
        end else begin
            start_s = 1'b0;
        end
        load1_s = start_s;
        clr_s   = complete_s;
    end

    // Assemble the outgoing frame: stored slots below, the live sample on top.
    always_comb begin
        frame_word_s = '0;
        for (int i = 0; i < N_CH - 1; i++) begin
            frame_word_s[i*W +: W] = shadow_r[i];
        end
        frame_word_s[(N_CH-1)*W +: W] = din;
    end

    // Framing FSM with shadow array and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= HUNT;
            dout_r        <= '0;
            frame_valid_r <= 1'b0;
            sync_err_r    <= 1'b0;
            for (int i = 0; i < N_CH - 1; i++) begin
                shadow_r[i] <= '0;
            end
        end else begin
            frame_valid_r <= complete_s;
            sync_err_r    <= abort_s;
            if (start_s) begin
                shadow_r[0] <= din;
                state_r     <= RECV;
            end else if (inc_s) begin
                shadow_r[slot_s] <= din;
            end else if (complete_s) begin
                dout_r <= frame_word_s;
`ifdef TDM_DEMUX_FLYWHEEL_EN
                state_r <= RECV;
`else
                state_r <= HUNT;
`endif
            end else begin
                state_r <= state_r;
            end
        end
    end

    assign dout        = dout_r;
    assign frame_valid = frame_valid_r;
    assign sync_err    = sync_err_r;

endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: directed self-checking bench for tdm_demux (N_CH=4, W=8).
// Expectations follow TDM_DEMUX_FLYWHEEL_EN where the behaviour differs.
module tb_tdm_demux;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  din = 8'h00;
    logic        din_valid = 1'b0;
    logic        frame_sync = 1'b0;
    logic [31:0] dout;
    logic        frame_valid;
    logic        sync_err;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;
    int fv_cnt   = 0;
    int se_cnt   = 0;
    int fv_cyc [$];

    tdm_demux #(.N_CH(4), .W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .frame_sync  (frame_sync),
        .dout        (dout),
        .frame_valid (frame_valid),
        .sync_err    (sync_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, sample #1 after posedge, tally strobes.
    task automatic send(input logic v, input logic s, input logic [7:0] d);
        @(negedge clk);
        din_valid  = v;
        frame_sync = s;
        din        = d;
        @(posedge clk);
        #1;
        cyc++;
        if (frame_valid === 1'b1) begin
            fv_cnt++;
            fv_cyc.push_back(cyc);
        end
        if (sync_err === 1'b1) se_cnt++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(1'b0, 1'b0, 8'h00);
    endtask

    task automatic clear_counts();
        fv_cnt = 0;
        se_cnt = 0;
        fv_cyc.delete();
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        din_valid = 1'b0;
        frame_sync = 1'b0;
        @(posedge clk);
        #1;
        check_val("rst_dout", dout, 32'h0);
        check_val("rst_fv", frame_valid, 1'b0);
        check_val("rst_se", sync_err, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        pulse_reset();

        // Basic frame on consecutive cycles
        clear_counts();
        send(1'b1, 1'b1, 8'hA0);
        send(1'b1, 1'b0, 8'hB1);
        send(1'b1, 1'b0, 8'hC2);
        check_val("basic_fv_early", frame_valid, 1'b0);
        send(1'b1, 1'b0, 8'hD3);
        check_val("basic_dout", dout, 32'hD3C2B1A0);
        check_val("basic_fv", frame_valid, 1'b1);
        check_val("basic_se", sync_err, 1'b0);
        idle(1);
        check_val("basic_fv_drop", frame_valid, 1'b0);
        check_val("basic_dout_hold", dout, 32'hD3C2B1A0);
        check_val("basic_fv_cnt", fv_cnt, 1);

        // Same frame with 3-cycle gaps; start from a cleared dout to see the update
        pulse_reset();
        clear_counts();
        send(1'b1, 1'b1, 8'hA0); idle(3);
        send(1'b1, 1'b0, 8'hB1); idle(3);
        send(1'b1, 1'b0, 8'hC2); idle(3);
        send(1'b1, 1'b0, 8'hD3);
        check_val("gap_fv", frame_valid, 1'b1);
        idle(3);
        check_val("gap_dout", dout, 32'hD3C2B1A0);
        check_val("gap_fv_cnt", fv_cnt, 1);
        check_val("gap_se_cnt", se_cnt, 0);

        // Unmarked samples from HUNT are dropped
        pulse_reset();
        clear_counts();
        send(1'b1, 1'b0, 8'h11);
        send(1'b1, 1'b0, 8'h22);
        send(1'b1, 1'b1, 8'h01);
        send(1'b1, 1'b0, 8'h02);
        send(1'b1, 1'b0, 8'h03);
        send(1'b1, 1'b0, 8'h04);
        idle(1);
        check_val("drop_dout", dout, 32'h04030201);
        check_val("drop_fv_cnt", fv_cnt, 1);
        check_val("drop_se_cnt", se_cnt, 0);

        // Early frame_sync aborts the partial frame
        clear_counts();
        send(1'b1, 1'b1, 8'h10);
        send(1'b1, 1'b0, 8'h20);
        send(1'b1, 1'b1, 8'h30);
        check_val("abort_se", sync_err, 1'b1);
        check_val("abort_fv", frame_valid, 1'b0);
        check_val("abort_dout_kept", dout, 32'h04030201);
        send(1'b1, 1'b0, 8'h40);
        check_val("abort_se_drop", sync_err, 1'b0);
        send(1'b1, 1'b0, 8'h50);
        send(1'b1, 1'b0, 8'h60);
        idle(1);
        check_val("abort_dout", dout, 32'h60504030);
        check_val("abort_fv_cnt", fv_cnt, 1);
        check_val("abort_se_cnt", se_cnt, 1);

        // Reset in the middle of a frame
        clear_counts();
        send(1'b1, 1'b1, 8'h71);
        send(1'b1, 1'b0, 8'h72);
        pulse_reset();
        send(1'b1, 1'b1, 8'h05);
        send(1'b1, 1'b0, 8'h06);
        send(1'b1, 1'b0, 8'h07);
        send(1'b1, 1'b0, 8'h08);
        idle(1);
        check_val("midrst_dout", dout, 32'h08070605);
        check_val("midrst_fv_cnt", fv_cnt, 1);

        // Back-to-back frames, second one unmarked
        clear_counts();
        send(1'b1, 1'b1, 8'h11);
        send(1'b1, 1'b0, 8'h12);
        send(1'b1, 1'b0, 8'h13);
        send(1'b1, 1'b0, 8'h14);
        send(1'b1, 1'b0, 8'h21);
        send(1'b1, 1'b0, 8'h22);
        send(1'b1, 1'b0, 8'h23);
        send(1'b1, 1'b0, 8'h24);
        idle(2);
`ifdef TDM_DEMUX_FLYWHEEL_EN
        check_val("b2b_dout", dout, 32'h24232221);
        check_val("b2b_fv_cnt", fv_cnt, 2);
        if (fv_cyc.size() == 2) begin
            check_val("b2b_spacing", fv_cyc[1] - fv_cyc[0], 4);
        end else begin
            check_val("b2b_spacing_pulses", fv_cyc.size(), 2);
        end
`else
        check_val("b2b_dout", dout, 32'h14131211);
        check_val("b2b_fv_cnt", fv_cnt, 1);
`endif
        check_val("b2b_se_cnt", se_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
